// File: rtl/axilxbar_addrdecode_skid.sv
// axilxbar_addrdecode_skid: registered AXI-lite address decoder with a
// one-entry skid buffer. Each accepted request is turned into a one-hot
// slave select, where bit NS means "no slave". o_stall is registered, and
// the block sustains one beat per clock. It also keeps a saturating count
// of unmapped requests.
// Optional build macro: ADDRDECODE_LOWPOWER_EN. When defined, the output
// and skid datapaths are zeroed whenever they hold no valid entry.
module axilxbar_addrdecode_skid #(
  parameter int NS = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NS*AW-1:0] SLAVE_ADDR =
    {32'h8000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NS*AW-1:0] SLAVE_MASK =
    {32'h8000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter logic [NS-1:0] ACCESS_ALLOWED = {NS{1'b1}},
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_stall,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_stall,
  output logic [NS:0]   o_decode,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] o_miss_count
);

  logic          out_vld_q;
  logic [AW-1:0] out_addr_q;
  logic [DW-1:0] out_data_q;
  logic [NS:0]   out_dec_q;
  logic          skid_vld_q;
  logic [AW-1:0] skid_addr_q;
  logic [DW-1:0] skid_data_q;
  logic [NS:0]   skid_dec_q;
  logic [CW-1:0] miss_q;
  logic [NS:0]   dec_d;
  logic          accept;
  logic          out_load;

  // Fixed-priority decode: scan from the top down so the lowest index wins
  always_comb begin
    dec_d     = '0;
    dec_d[NS] = 1'b1;
    for (int k = NS - 1; k >= 0; k--) begin
      if ((((i_addr ^ SLAVE_ADDR[k*AW +: AW]) & SLAVE_MASK[k*AW +: AW]) == '0)
          && ACCESS_ALLOWED[k]) begin
        dec_d    = '0;
        dec_d[k] = 1'b1;
      end
    end
  end

  assign accept   = i_valid && !skid_vld_q;
  assign out_load = !out_vld_q || !i_stall;

  // Output register plus skid entry. The skid entry has priority when the
  // output can load, so beats are never reordered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_vld_q  <= 1'b0;
      out_dec_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dec_q <= '0;
`ifdef ADDRDECODE_LOWPOWER_EN
      out_addr_q  <= '0;
      out_data_q  <= '0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
`endif
    end else if (out_load) begin
      if (skid_vld_q) begin
        out_vld_q  <= 1'b1;
        out_addr_q <= skid_addr_q;
        out_data_q <= skid_data_q;
        out_dec_q  <= skid_dec_q;
        skid_vld_q <= 1'b0;
        skid_dec_q <= '0;
`ifdef ADDRDECODE_LOWPOWER_EN
        skid_addr_q <= '0;
        skid_data_q <= '0;
`endif
      end else if (accept) begin
        out_vld_q  <= 1'b1;
        out_addr_q <= i_addr;
        out_data_q <= i_data;
        out_dec_q  <= dec_d;
      end else begin
        out_vld_q <= 1'b0;
        out_dec_q <= '0;
`ifdef ADDRDECODE_LOWPOWER_EN
        out_addr_q <= '0;
        out_data_q <= '0;
`endif
      end
    end else if (accept) begin
      // The output is held by downstream, so the beat parks in the skid entry
      skid_vld_q  <= 1'b1;
      skid_addr_q <= i_addr;
      skid_data_q <= i_data;
      skid_dec_q  <= dec_d;
    end
  end

  // Saturating count of unmapped beats, taken at acceptance
  always_ff @(posedge i_clk) begin
    if (i_reset)
      miss_q <= '0;
    else if (accept && dec_d[NS] && (miss_q != {CW{1'b1}}))
      miss_q <= miss_q + 1'b1;
  end

  assign o_stall      = skid_vld_q;
  assign o_valid      = out_vld_q;
  assign o_decode     = out_dec_q;
  assign o_addr       = out_addr_q;
  assign o_data       = out_data_q;
  assign o_miss_count = miss_q;

endmodule
